lsu_unit: RTL and testbench

Load/store unit that executes the memory requests issued by the instruction decoder (mem_rw, funct3, ALU address, rs2 data) and returns load data with a completion strobe (data_vld) to the datapath. It is the responding end of the decoder's memory-control interface and the initiating end of the data-memory bus. It handles byte-lane steering, load sign/zero extension, misalignment detection and a req/gnt/rvalid bus handshake.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_align.sv | 44 ++++
 rtl/lsu_unit.sv | 151 +++++++++++++++
 tb/tb_lsu_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, memory-op encoding, funct3 sizes and fault classes.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_MISALIGN = 2'd1,
        FLT_ILLEGAL  = 2'd2
    } fault_e;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic fault_e lsu_fault(input logic rw, input logic [2:0] f3,
                                         input logic [1:0] alo);
        logic legal;
        if (rw == MEM_WRITE)
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        if (!legal)
            return FLT_ILLEGAL;
        if ((f3[1:0] == 2'b01) && alo[0])
            return FLT_MISALIGN;
        if ((f3[1:0] == 2'b10) && (alo != 2'b00))
            return FLT_MISALIGN;
        return FLT_NONE;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads (32-bit bus).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shifted;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_st_data;
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending.
    always_comb begin
        w_shifted = i_rdata >> {i_addr_lo, 3'b000};
        case (i_funct3)
            F3_B:    o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   o_ld_data = {24'h0, w_shifted[7:0]};
            F3_HU:   o_ld_data = {16'h0, w_shifted[15:0]};
            default: o_ld_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: decoder request in, req/gnt/rvalid data-bus master out, one-cycle completion strobe.
// Optional LSU_TIMEOUT_EN adds a bus watchdog that faults the access after TIMEOUT_CYC cycles.
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_vld,
    input  logic              mem_rw,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              req_rdy,
    output logic [DATA_W-1:0] ld_data,
    output logic              data_vld,
    output logic              acc_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    lsu_state_e  r_state;
    logic        r_rw;
    logic [2:0]  r_f3;
    logic [1:0]  r_alo;

    logic [2:0]  w_f3;
    logic [1:0]  w_alo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_ext;
    fault_e      w_fault;
    logic        w_timeout;

    // In IDLE the aligner sees the live request so steering can be registered at accept;
    // afterwards it sees the latched fields for load extraction.
    assign w_f3    = (r_state == ST_IDLE) ? funct3 : r_f3;
    assign w_alo   = (r_state == ST_IDLE) ? addr[1:0] : r_alo;
    assign w_fault = lsu_fault(mem_rw, funct3, addr[1:0]);

    lsu_align u_align (
        .i_funct3  (w_f3),
        .i_addr_lo (w_alo),
        .i_st_data (st_data),
        .i_rdata   (bus_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_ld_data (w_ld_ext)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_cnt;

    assign w_timeout = (r_state == ST_REQ || r_state == ST_WAIT) &&
                       (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_state == ST_IDLE)
            r_cnt <= '0;
        else if (r_state == ST_REQ || r_state == ST_WAIT)
            r_cnt <= r_cnt + 1'b1;
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rw      <= 1'b0;
            r_f3      <= 3'b000;
            r_alo     <= 2'b00;
            req_rdy   <= 1'b1;
            ld_data   <= '0;
            data_vld  <= 1'b0;
            acc_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= '0;
        end else begin
            data_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_vld) begin
                        r_rw    <= mem_rw;
                        r_f3    <= funct3;
                        r_alo   <= addr[1:0];
                        req_rdy <= 1'b0;
                        if (w_fault != FLT_NONE) begin
                            r_state  <= ST_DONE;
                            data_vld <= 1'b1;
                            acc_err  <= 1'b1;
                        end else begin
                            r_state   <= ST_REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_rw;
                            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus_be    <= w_be;
                            bus_wdata <= w_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (w_timeout) begin
                        r_state  <= ST_DONE;
                        bus_req  <= 1'b0;
                        data_vld <= 1'b1;
                        acc_err  <= 1'b1;
                    end else if (bus_gnt) begin
                        r_state <= ST_WAIT;
                        bus_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (w_timeout) begin
                        r_state  <= ST_DONE;
                        data_vld <= 1'b1;
                        acc_err  <= 1'b1;
                    end else if (bus_rvalid) begin
                        r_state  <= ST_DONE;
                        data_vld <= 1'b1;
                        acc_err  <= 1'b0;
                        if (r_rw == MEM_READ)
                            ld_data <= w_ld_ext;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    req_rdy <= 1'b1;
                    acc_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit; the watchdog case runs only when LSU_TIMEOUT_EN is defined.
module tb_lsu_unit;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_vld = 1'b0;
    logic              mem_rw = 1'b0;
    logic [2:0]        funct3 = 3'b000;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] st_data = '0;
    logic              req_rdy;
    logic [DATA_W-1:0] ld_data;
    logic              data_vld;
    logic              acc_err;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_gnt = 1'b0;
    logic              bus_rvalid = 1'b0;
    logic [DATA_W-1:0] bus_rdata = '0;

    lsu_unit #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_vld    (req_vld),
        .mem_rw     (mem_rw),
        .funct3     (funct3),
        .addr       (addr),
        .st_data    (st_data),
        .req_rdy    (req_rdy),
        .ld_data    (ld_data),
        .data_vld   (data_vld),
        .acc_err    (acc_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int          t_lat;
    logic        t_err;
    logic [31:0] t_ld;
    bit          t_req_seen;
    bit          t_stable;
    logic        t_bwe;
    logic [31:0] t_baddr;
    logic [3:0]  t_bbe;
    logic [31:0] t_bwdata;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_req_rdy"},  {31'h0, req_rdy},  32'h1);
        check_val({pfx, "_ld_data"},  ld_data,           32'h0);
        check_val({pfx, "_data_vld"}, {31'h0, data_vld}, 32'h0);
        check_val({pfx, "_acc_err"},  {31'h0, acc_err},  32'h0);
        check_val({pfx, "_bus_req"},  {31'h0, bus_req},  32'h0);
        check_val({pfx, "_bus_we"},   {31'h0, bus_we},   32'h0);
        check_val({pfx, "_bus_addr"}, bus_addr,          32'h0);
        check_val({pfx, "_bus_be"},   {28'h0, bus_be},   32'h0);
        check_val({pfx, "_bus_wdata"},bus_wdata,         32'h0);
    endtask

    // Issue one request at edge 0 and act as the bus slave; cycle c is the cycle after edge c-1.
    // While waiting for a grant, a junk rvalid is driven so a DUT that honours it in REQ is caught.
    task automatic run_op(input string tag, input logic rw, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                          input int gdly, input int rdly, input bit hold, input int budget);
        int nreq;
        int nwait;
        bit done;
        nreq = 0; nwait = 0; done = 0;
        t_lat = -1; t_err = 1'bx; t_ld = 'x; t_req_seen = 0; t_stable = 1;
        @(negedge clk);
        req_vld = 1'b1; mem_rw = rw; funct3 = f3; addr = a; st_data = sd;
        @(posedge clk);
        for (int c = 1; c <= budget && !done; c++) begin
            @(negedge clk);
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
            if (hold) begin
                addr = 32'h0000_0999; funct3 = 3'b000; st_data = ~sd;
            end else begin
                req_vld = 1'b0;
            end
            if (data_vld) begin
                done = 1; t_lat = c; t_err = acc_err; t_ld = ld_data; req_vld = 1'b0;
            end else if (bus_req) begin
                if (!t_req_seen) begin
                    t_bwe = bus_we; t_baddr = bus_addr; t_bbe = bus_be; t_bwdata = bus_wdata;
                end else if (bus_we !== t_bwe || bus_addr !== t_baddr ||
                             bus_be !== t_bbe || bus_wdata !== t_bwdata) begin
                    t_stable = 0;
                end
                t_req_seen = 1;
                if (nreq >= gdly) begin
                    bus_gnt = 1'b1;
                end else begin
                    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
                end
                nreq++;
            end else if (t_req_seen) begin
                if (nwait >= rdly) begin
                    bus_rvalid = 1'b1; bus_rdata = rd;
                end
                nwait++;
            end
        end
        check_val({tag, "_done"}, {31'h0, done}, 32'h1);
        req_vld = 1'b0;
        @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        check_val({tag, "_vld_pulse"}, {31'h0, data_vld}, 32'h0);
        check_val({tag, "_rdy_back"},  {31'h0, req_rdy},  32'h1);
    endtask

    task automatic check_no_vld_after_reset(input string tag);
        bit seen;
        seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_gnt = (i == 0); bus_rvalid = 1'b1; bus_rdata = 32'h7777_7777;
            if (data_vld) seen = 1;
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        check_val({tag, "_no_vld"}, {31'h0, seen}, 32'h0);
        check_val({tag, "_ld_kept"}, ld_data, 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // LB at 0x103: top byte 0x80 sign-extends.
        run_op("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 0, 1'b0, 20);
        check_val("lb_lat",  t_lat, 3);
        check_val("lb_err",  {31'h0, t_err}, 32'h0);
        check_val("lb_data", t_ld, 32'hFFFF_FF80);
        check_val("lb_be",   {28'h0, t_bbe}, 32'h8);
        check_val("lb_addr", t_baddr, 32'h100);
        check_val("lb_we",   {31'h0, t_bwe}, 32'h0);

        run_op("lhu", 1'b0, 3'b101, 32'h202, 32'h0, 32'hBEEF_1234, 0, 0, 1'b0, 20);
        check_val("lhu_be",   {28'h0, t_bbe}, 32'hC);
        check_val("lhu_addr", t_baddr, 32'h200);
        check_val("lhu_data", t_ld, 32'h0000_BEEF);

        run_op("sb", 1'b1, 3'b000, 32'h1, 32'h1234_56AB, 32'hFFFF_FFFF, 0, 0, 1'b0, 20);
        check_val("sb_lat",   t_lat, 3);
        check_val("sb_we",    {31'h0, t_bwe}, 32'h1);
        check_val("sb_be",    {28'h0, t_bbe}, 32'h2);
        check_val("sb_wdata", t_bwdata, 32'hABAB_ABAB);
        check_val("sb_ld",    t_ld, 32'h0000_BEEF);

        run_op("lw_mis", 1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 0, 0, 1'b0, 20);
        check_val("lw_mis_lat", t_lat, 1);
        check_val("lw_mis_err", {31'h0, t_err}, 32'h1);
        check_val("lw_mis_req", {31'h0, t_req_seen}, 32'h0);
        check_val("lw_mis_ld",  t_ld, 32'h0000_BEEF);

        // Delayed grant/ack with the request inputs wiggling while busy.
        run_op("sw_slow", 1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, 32'h0, 5, 3, 1'b1, 40);
        check_val("sw_slow_lat",    t_lat, 11);
        check_val("sw_slow_stable", {31'h0, t_stable}, 32'h1);
        check_val("sw_slow_be",     {28'h0, t_bbe}, 32'hF);
        check_val("sw_slow_wdata",  t_bwdata, 32'hCAFE_F00D);
        check_val("sw_slow_err",    {31'h0, t_err}, 32'h0);
        check_val("sw_slow_ld",     t_ld, 32'h0000_BEEF);

        run_op("lh", 1'b0, 3'b001, 32'h2, 32'h0, 32'h8001_0000, 0, 0, 1'b0, 20);
        check_val("lh_data", t_ld, 32'hFFFF_8001);
        check_val("lh_be",   {28'h0, t_bbe}, 32'hC);

        run_op("lbu", 1'b0, 3'b100, 32'h0, 32'h0, 32'h1234_56F0, 0, 0, 1'b0, 20);
        check_val("lbu_data", t_ld, 32'h0000_00F0);
        check_val("lbu_be",   {28'h0, t_bbe}, 32'h1);

        run_op("lw", 1'b0, 3'b010, 32'h4, 32'h0, 32'h1234_5678, 0, 1, 1'b0, 20);
        check_val("lw_lat",  t_lat, 4);
        check_val("lw_data", t_ld, 32'h1234_5678);
        check_val("lw_addr", t_baddr, 32'h4);

        run_op("sh", 1'b1, 3'b001, 32'h2, 32'h0000_BEEF, 32'h0, 0, 0, 1'b0, 20);
        check_val("sh_be",    {28'h0, t_bbe}, 32'hC);
        check_val("sh_wdata", t_bwdata, 32'hBEEF_BEEF);

        run_op("ld_ill", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0, 20);
        check_val("ld_ill_err", {31'h0, t_err}, 32'h1);
        check_val("ld_ill_lat", t_lat, 1);
        check_val("ld_ill_req", {31'h0, t_req_seen}, 32'h0);

        run_op("st_ill", 1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0, 20);
        check_val("st_ill_err", {31'h0, t_err}, 32'h1);
        check_val("st_ill_req", {31'h0, t_req_seen}, 32'h0);

        run_op("lh_mis", 1'b0, 3'b001, 32'h1, 32'h0, 32'h0, 0, 0, 1'b0, 20);
        check_val("lh_mis_err", {31'h0, t_err}, 32'h1);
        check_val("lh_mis_ld",  t_ld, 32'h1234_5678);

`ifdef LSU_TIMEOUT_EN
        run_op("tmo", 1'b0, 3'b010, 32'h8, 32'h0, 32'h0, 1000, 0, 1'b0, 60);
        check_val("tmo_lat", t_lat, TIMEOUT_CYC + 1);
        check_val("tmo_err", {31'h0, t_err}, 32'h1);
        check_val("tmo_ld",  t_ld, 32'h1234_5678);
`endif

        // Reset while bus_req is up: it must fall without waiting for a clock edge.
        @(negedge clk);
        req_vld = 1'b1; mem_rw = 1'b1; funct3 = 3'b010; addr = 32'h40; st_data = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_vld = 1'b0;
        check_val("rstreq_pre", {31'h0, bus_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rstreq");
        check_no_vld_after_reset("rstreq");

        // Reload a nonzero ld_data, then reset in WAIT.
        run_op("lw2", 1'b0, 3'b010, 32'h20, 32'h0, 32'hA5A5_0001, 0, 0, 1'b0, 20);
        check_val("lw2_data", t_ld, 32'hA5A5_0001);
        @(negedge clk);
        req_vld = 1'b1; mem_rw = 1'b0; funct3 = 3'b010; addr = 32'h24;
        @(posedge clk);
        @(negedge clk);
        req_vld = 1'b0; bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        check_val("rstwait_pre", ld_data, 32'hA5A5_0001);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rstwait");
        check_no_vld_after_reset("rstwait");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
